// File: rtl/multicycle_control_if.sv
// Control bus of the multi-cycle MIPS controller.
// Carries the IR opcode and memory handshake into the controller and the
// datapath controls, retire/trap status, retired count and debug state out.
//   master : controller side (drives controls, reads opcode/mem_ready)
//   slave  : datapath side
interface multicycle_control_if #(
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned CNT_W    = 32
);
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          pc_source;
  logic                retire;
  logic                illegal_op;
  logic [CNT_W-1:0]    instr_count;
  logic [3:0]          state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, retire, illegal_op, instr_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, retire, illegal_op, instr_count, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the shared-memory MIPS datapath.
// Sequences lw/sw/R-type/addi/andi/beq/j over several cycles, stretches
// FETCH/MEMRD/MEMWR on mem_ready, traps illegal opcodes (sticky until reset)
// and counts retired instructions.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : multicycle_control_if.master (opcode/mem_ready in, controls out)
module multicycle_control #(
  parameter int unsigned ALU_OP_W    = 2,
  parameter bit          ENABLE_ANDI = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_REXE   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BEQ    = 4'd9,
    ST_IEXE   = 4'd10,
    ST_IWB    = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RST;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (bus.retire)
        r_count <= r_count + CNT_W'(1);
      // Set on entry so the flag is already high during the first TRAP cycle.
      if (w_next == ST_TRAP)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_ADD;
    bus.pc_source     = 2'b00;
    bus.retire        = 1'b0;

    case (r_state)
      ST_RST: w_next = ST_FETCH;
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC load only on the cycle the fetch completes.
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          6'd0:         w_next = ST_REXE;
          6'd35, 6'd43: w_next = ST_MEMADR;
          6'd8:         w_next = ST_IEXE;
          6'd12:        w_next = ENABLE_ANDI ? ST_IEXE : ST_TRAP;
          6'd4:         w_next = ST_BEQ;
          6'd2:         w_next = ST_JUMP;
          default:      w_next = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        w_next = (bus.opcode == 6'd43) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
        w_next         = ST_FETCH;
      end
      ST_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        bus.retire    = bus.mem_ready;
        if (bus.mem_ready) w_next = ST_FETCH;
      end
      ST_REXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FN;
        w_next        = ST_RWB;
      end
      ST_RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.retire    = 1'b1;
        w_next        = ST_FETCH;
      end
      ST_IEXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = (ENABLE_ANDI && bus.opcode == 6'd12) ? ALU_AND : ALU_ADD;
        w_next        = ST_IWB;
      end
      ST_IWB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        w_next        = ST_FETCH;
      end
      ST_BEQ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.retire        = 1'b1;
        w_next            = ST_FETCH;
      end
      ST_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        bus.retire    = 1'b1;
        w_next        = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_RST;
    endcase
  end

  assign bus.illegal_op  = r_illegal;
  assign bus.instr_count = r_count;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (andi enabled / 32-bit counter,
// andi disabled / 2-bit counter) share opcode and mem_ready; the unused one is
// held in reset. Retire events are checked against a queue of expected
// results filled by the stimulus.
module tb_multicycle_control;

  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_MEMRD = 4'd4;
  localparam logic [3:0] S_MEMWB = 4'd5;
  localparam logic [3:0] S_MEMWR = 4'd6;
  localparam logic [3:0] S_RWB   = 4'd8;
  localparam logic [3:0] S_BEQ   = 4'd9;
  localparam logic [3:0] S_IEXE  = 4'd10;
  localparam logic [3:0] S_IWB   = 4'd11;
  localparam logic [3:0] S_JUMP  = 4'd12;
  localparam logic [3:0] S_TRAP  = 4'd13;

  // ctl = {pc_write, pc_write_cond, mem_read, mem_write, iord,
  //        reg_write, reg_dst, mem_to_reg, pc_source[1:0]}
  localparam logic [9:0] C_RWB   = 10'b0000011000;
  localparam logic [9:0] C_MEMWB = 10'b0000010100;
  localparam logic [9:0] C_MEMWR = 10'b0001100000;
  localparam logic [9:0] C_IWB   = 10'b0000010000;
  localparam logic [9:0] C_BEQ   = 10'b0100000001;
  localparam logic [9:0] C_JUMP  = 10'b1000000010;

  typedef struct {
    string      name;
    logic [3:0] st;
    int         cyc;
    logic [31:0] cnt;
    logic [9:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, sel, mem_ready;
  logic [5:0] opcode;
  int         n_checks = 0;
  int         n_err    = 0;
  int         model_cnt = 0;
  exp_t       sb[$];

  multicycle_control_if #(.ALU_OP_W(2), .CNT_W(32)) ifa ();
  multicycle_control_if #(.ALU_OP_W(2), .CNT_W(2))  ifb ();

  assign ifa.opcode    = opcode;
  assign ifa.mem_ready = mem_ready;
  assign ifb.opcode    = opcode;
  assign ifb.mem_ready = mem_ready;

  multicycle_control #(.ALU_OP_W(2), .ENABLE_ANDI(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.master));
  multicycle_control #(.ALU_OP_W(2), .ENABLE_ANDI(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.master));

  logic [9:0]  ctl_a, ctl_b, m_ctl;
  logic [5:0]  misc_a, misc_b, m_misc;
  logic [31:0] m_cnt;
  logic [3:0]  m_state;
  logic        m_retire, m_illegal;
  logic [53:0] m_all;

  assign ctl_a = {ifa.pc_write, ifa.pc_write_cond, ifa.mem_read, ifa.mem_write, ifa.iord,
                  ifa.reg_write, ifa.reg_dst, ifa.mem_to_reg, ifa.pc_source};
  assign ctl_b = {ifb.pc_write, ifb.pc_write_cond, ifb.mem_read, ifb.mem_write, ifb.iord,
                  ifb.reg_write, ifb.reg_dst, ifb.mem_to_reg, ifb.pc_source};
  assign misc_a = {ifa.ir_write, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op};
  assign misc_b = {ifb.ir_write, ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op};
  assign m_ctl     = sel ? ctl_b : ctl_a;
  assign m_misc    = sel ? misc_b : misc_a;
  assign m_cnt     = sel ? {30'b0, ifb.instr_count} : ifa.instr_count;
  assign m_state   = sel ? ifb.state : ifa.state;
  assign m_retire  = sel ? ifb.retire : ifa.retire;
  assign m_illegal = sel ? ifb.illegal_op : ifa.illegal_op;
  assign m_all     = {m_ctl, m_misc, m_retire, m_illegal, m_cnt, m_state};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_count();
    return sel ? (model_cnt & 32'd3) : model_cnt;
  endfunction

  // Monitor: tracks cycle number within the current instruction and checks
  // every retire against the oldest queued expectation.
  int         mon_cyc = 0;
  logic [3:0] mon_prev = 4'd0;
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (m_state == S_FETCH && mon_prev != S_FETCH) mon_cyc = 1;
    else mon_cyc++;
    mon_prev = m_state;
    if (m_retire) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_retire_state"}, m_state, e.st);
        chk({e.name, "_retire_cycle"}, mon_cyc, e.cyc);
        chk({e.name, "_retire_count"}, m_cnt, e.cnt);
        chk({e.name, "_retire_ctl"},   m_ctl, e.ctl);
      end
    end
  end

  // Runs one instruction until it retires; called while the DUT is in (or
  // about to enter) FETCH. mem_waits stalls MEMRD/MEMWR for that many cycles.
  task automatic issue(input string name, input logic [5:0] op, input logic [3:0] est,
                       input int ecyc, input logic [9:0] ectl, input int mem_waits,
                       output int memwr_cycles);
    exp_t e;
    int   mw   = 0;
    bit   done = 1'b0;
    e.name = name; e.st = est; e.cyc = ecyc; e.cnt = exp_count(); e.ctl = ectl;
    sb.push_back(e);
    memwr_cycles = 0;
    opcode = op;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if ((m_state == S_MEMRD || m_state == S_MEMWR) && mw < mem_waits) begin
        mem_ready = 1'b0;
        mw++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (i == 0) chk({name, "_count_before"}, m_cnt, exp_count());
      if (m_state == S_IEXE) chk({name, "_iexe_alu_op"}, m_misc[1:0], (op == 6'd12) ? 2'b11 : 2'b00);
      if (m_state == S_BEQ)  chk({name, "_beq_alu_op"}, m_misc[1:0], 2'b01);
      if (m_ctl[6] && m_ctl[5]) memwr_cycles++;
      if (m_retire) done = 1'b1;
    end
    if (!done) chk({name, "_timeout"}, 64'd0, 64'd1);
    model_cnt++;
  endtask

  task automatic trap_check(input string name, input logic [5:0] op);
    bit in_trap = 1'b0;
    int bad = 0;
    opcode = op;
    for (int i = 0; i < 8 && !in_trap; i++) begin
      @(negedge clk); #2;
      if (m_state == S_TRAP) in_trap = 1'b1;
    end
    chk({name, "_reached_trap"}, in_trap, 1'b1);
    chk({name, "_illegal_op"}, m_illegal, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (m_state != S_TRAP || !m_illegal || m_ctl[9] || m_ctl[8] || m_ctl[6] ||
          m_ctl[4] || m_misc[5] || m_retire)
        bad++;
    end
    chk({name, "_trap_quiet_10"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int mwc;
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; opcode = 6'd0; mem_ready = 1'b1;

    // Reset held 3 cycles: everything zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("reset_outputs_zero", m_all, 54'd0);
    end
    @(negedge clk); #1 rst_a = 1'b1;
    @(negedge clk); #2;
    chk("fetch_after_release", m_state, S_FETCH);

    issue("rtype", 6'd0,  S_RWB,   4, C_RWB,   0, mwc);
    issue("lw",    6'd35, S_MEMWB, 5, C_MEMWB, 0, mwc);
    issue("sw",    6'd43, S_MEMWR, 7, C_MEMWR, 3, mwc);
    chk("sw_memwrite_held", mwc, 4);
    issue("beq",   6'd4,  S_BEQ,   3, C_BEQ,   0, mwc);
    issue("j",     6'd2,  S_JUMP,  3, C_JUMP,  0, mwc);
    issue("andi",  6'd12, S_IWB,   4, C_IWB,   0, mwc);
    issue("addi",  6'd8,  S_IWB,   4, C_IWB,   0, mwc);
    @(negedge clk); #2;
    chk("count_after_seven", m_cnt, 32'd7);

    // Reset while a load is waiting in MEMRD.
    begin
      bit reached = 1'b0;
      opcode = 6'd35;
      for (int i = 0; i < 10 && !reached; i++) begin
        @(negedge clk); #1;
        mem_ready = (m_state == S_MEMRD) ? 1'b0 : 1'b1;
        #1;
        if (m_state == S_MEMRD) reached = 1'b1;
      end
      chk("midlw_reached_memrd", reached, 1'b1);
      chk("midlw_mem_read", m_ctl[7], 1'b1);
      #1 rst_a = 1'b0;
      #1 chk("midlw_async_reset_zero", m_all, 54'd0);
    end
    @(negedge clk); #1 mem_ready = 1'b1; model_cnt = 0; rst_a = 1'b1;
    trap_check("op63_andi_on", 6'd63);

    // Second instance: 2-bit counter wrap, andi disabled.
    @(negedge clk); #1 rst_a = 1'b0; sel = 1'b1; opcode = 6'd2;
    @(negedge clk); #2 chk("b_reset_zero", m_all, 54'd0);
    #1 rst_b = 1'b1;
    for (int k = 0; k < 5; k++) issue("b_j", 6'd2, S_JUMP, 3, C_JUMP, 0, mwc);
    @(negedge clk); #2;
    chk("b_count_wrap", m_cnt, 32'd1);
    trap_check("andi_disabled", 6'd12);

    @(negedge clk); #1 rst_b = 1'b0;
    #1 chk("b_reset_clears_trap", m_illegal, 1'b0);
    @(negedge clk); #1 rst_b = 1'b1; model_cnt = 0;
    trap_check("op63_andi_off", 6'd63);

    @(negedge clk); #4;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
